eth_latency_log_parser: RTL and testbench

// - Receive end of the latency-measurer AXI-Stream log: consumes 48-byte log records, reassembles them, validates the header, and presents decoded fields.
// - Sits on the host/DMA side, or in a loopback test harness, downstream of the log serializer.
// - Record layout, LSB first: magic 32'h02425AFF, log_id[15:0], size 16'd40, current_time[63:0], ping_count[63:0],

---
 rtl/eth_latency_log_parser_if.sv | 43 ++++
 rtl/eth_latency_log_parser.sv | 122 ++++++++++++
 tb/tb_eth_latency_log_parser.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/eth_latency_log_parser_if.sv
// Log stream and decoded-record bundle for the latency log parser.
// master drives the stream and rec_ready; slave is the parser.
interface eth_latency_log_parser_if #(
   parameter int W = 64
) ();
   logic [W-1:0] s_axis_log_tdata;
   logic         s_axis_log_tlast;
   logic         s_axis_log_tvalid;
   logic         s_axis_log_tready;
   logic         rec_valid;
   logic         rec_ready;
   logic [15:0]  rec_log_id;
   logic [63:0]  rec_current_time;
   logic [63:0]  rec_ping_count;
   logic [31:0]  rec_ping_time;
   logic [31:0]  rec_pong_time;
   logic [63:0]  rec_pings_lost;
   logic [63:0]  rec_pongs_lost;
   logic [31:0]  err_header_count;
   logic [31:0]  err_length_count;

   modport master (
      output s_axis_log_tdata, s_axis_log_tlast,
      output s_axis_log_tvalid, rec_ready,
      input  s_axis_log_tready, rec_valid,
      input  rec_log_id, rec_current_time,
      input  rec_ping_count, rec_ping_time,
      input  rec_pong_time, rec_pings_lost,
      input  rec_pongs_lost,
      input  err_header_count, err_length_count
   );

   modport slave (
      input  s_axis_log_tdata, s_axis_log_tlast,
      input  s_axis_log_tvalid, rec_ready,
      output s_axis_log_tready, rec_valid,
      output rec_log_id, rec_current_time,
      output rec_ping_count, rec_ping_time,
      output rec_pong_time, rec_pings_lost,
      output rec_pongs_lost,
      output err_header_count, err_length_count
   );
endinterface

// File: rtl/eth_latency_log_parser.sv
// Reassembles 48-byte latency log records from a stream, checks the
// header and holds decoded fields until taken. Ports: clk, rst_n, bus.
module eth_latency_log_parser #(
   parameter int C_AXIS_LOG_WIDTH = 64
) (
   input logic clk,
   input logic rst_n,
   eth_latency_log_parser_if.slave bus
);
   localparam int W  = C_AXIS_LOG_WIDTH;
   localparam int N  = (W < 384) ? 384 / W : 1;
   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam logic [BW-1:0] LASTB = BW'(N - 1);
   localparam logic [31:0] MAGIC = 32'h02425AFF;

   typedef enum logic [1:0] {
      S_RECV,
      S_DISCARD,
      S_HOLD
   } state_e;

   state_e        st_q, st_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [383:0]  buf_q, buf_d;
   logic [383:0]  rec_q, rec_d;
   logic [383:0]  asm_w;
   logic [31:0]   hdr_q, hdr_d;
   logic [31:0]   len_q, len_d;
   logic          acc;
   logic          hdr_ok;

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   // Buffer as it will look once the current beat is shifted in; the
   // header check runs on this so the final beat is included.
   generate
      if (W < 384) begin : g_shift
         assign asm_w = {bus.s_axis_log_tdata, buf_q[383:W]};
      end else begin : g_wide
         assign asm_w = bus.s_axis_log_tdata[383:0];
      end
   endgenerate

   assign bus.s_axis_log_tready = rst_n & (st_q != S_HOLD);
   assign acc    = bus.s_axis_log_tvalid & bus.s_axis_log_tready;
   assign hdr_ok = (asm_w[31:0] == MAGIC) && (asm_w[63:48] == 16'd40);

   always_comb begin
      st_d   = st_q;
      beat_d = beat_q;
      buf_d  = buf_q;
      rec_d  = rec_q;
      hdr_d  = hdr_q;
      len_d  = len_q;
      unique case (st_q)
         S_RECV: begin
            if (acc) begin
               buf_d  = asm_w;
               beat_d = beat_q + BW'(1);
               if (beat_q == LASTB) begin
                  beat_d = '0;
                  if (bus.s_axis_log_tlast) begin
                     if (hdr_ok) begin
                        st_d  = S_HOLD;
                        rec_d = asm_w;
                     end else begin
                        hdr_d = sat_inc(hdr_q);
                     end
                  end else begin
                     len_d = sat_inc(len_q);
                     st_d  = S_DISCARD;
                  end
               end else if (bus.s_axis_log_tlast) begin
                  beat_d = '0;
                  len_d  = sat_inc(len_q);
               end
            end
         end
         S_DISCARD: begin
            if (acc && bus.s_axis_log_tlast) begin
               st_d   = S_RECV;
               beat_d = '0;
            end
         end
         S_HOLD: begin
            if (bus.rec_ready) st_d = S_RECV;
         end
         default: st_d = S_RECV;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= S_RECV;
         beat_q <= '0;
         buf_q  <= '0;
         rec_q  <= '0;
         hdr_q  <= '0;
         len_q  <= '0;
      end else begin
         st_q   <= st_d;
         beat_q <= beat_d;
         buf_q  <= buf_d;
         rec_q  <= rec_d;
         hdr_q  <= hdr_d;
         len_q  <= len_d;
      end
   end

   assign bus.rec_valid        = (st_q == S_HOLD);
   assign bus.rec_log_id       = rec_q[47:32];
   assign bus.rec_current_time = rec_q[127:64];
   assign bus.rec_ping_count   = rec_q[191:128];
   assign bus.rec_ping_time    = rec_q[223:192];
   assign bus.rec_pong_time    = rec_q[255:224];
   assign bus.rec_pings_lost   = rec_q[319:256];
   assign bus.rec_pongs_lost   = rec_q[383:320];
   assign bus.err_header_count = hdr_q;
   assign bus.err_length_count = len_q;
endmodule

// File: tb/tb_eth_latency_log_parser.sv
// Scoreboard bench for eth_latency_log_parser at W=64 (6 beats/record).
// Good records are queued when sent and checked when handed over.
module tb_eth_latency_log_parser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   eth_latency_log_parser_if #(.W(64)) bus ();

   eth_latency_log_parser #(.C_AXIS_LOG_WIDTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [383:0] sb[$];
   logic [383:0] e;
   logic [383:0] r;
   logic [31:0]  exp_hdr = 0;
   logic [31:0]  exp_len = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [383:0] mk(input logic [15:0] id,
                                       input logic [31:0] magic,
                                       input logic [15:0] size);
      logic [383:0] x;
      x[31:0]  = magic;
      x[47:32] = id;
      x[63:48] = size;
      for (int i = 2; i < 12; i++) x[i*32 +: 32] = $urandom();
      return x;
   endfunction

   function automatic logic [31:0] sat(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   task automatic drive_beat(input logic [63:0] d, input logic l);
      int t = 0;
      @(negedge clk);
      bus.s_axis_log_tdata  = d;
      bus.s_axis_log_tvalid = 1'b1;
      bus.s_axis_log_tlast  = l;
      while (!bus.s_axis_log_tready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) chk("tready_timeout", 0, 1);
      else @(posedge clk);
   endtask

   // kind: 0 good, 1 bad header, 2 bad length
   task automatic send(input logic [383:0] x, input int nb,
                       input int kind);
      logic [63:0] d;
      if (kind == 0) sb.push_back(x);
      if (kind == 1) exp_hdr = sat(exp_hdr);
      if (kind == 2) exp_len = sat(exp_len);
      for (int i = 0; i < nb; i++) begin
         d = (i < 6) ? x[i*64 +: 64] : {$urandom(), $urandom()};
         drive_beat(d, i == nb - 1);
      end
      @(negedge clk);
      bus.s_axis_log_tvalid = 1'b0;
      bus.s_axis_log_tlast  = 1'b0;
      chk("rec_valid_lat", bus.rec_valid, (kind == 0) ? 1 : 0);
      chk("err_hdr", bus.err_header_count, exp_hdr);
      chk("err_len", bus.err_length_count, exp_len);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rec_valid && bus.rec_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("log_id", bus.rec_log_id, e[47:32]);
            chk("cur_time", bus.rec_current_time, e[127:64]);
            chk("ping_cnt", bus.rec_ping_count, e[191:128]);
            chk("ping_time", bus.rec_ping_time, e[223:192]);
            chk("pong_time", bus.rec_pong_time, e[255:224]);
            chk("pings_lost", bus.rec_pings_lost, e[319:256]);
            chk("pongs_lost", bus.rec_pongs_lost, e[383:320]);
         end
      end
   end

   initial begin
      bus.s_axis_log_tdata  = '0;
      bus.s_axis_log_tvalid = 1'b0;
      bus.s_axis_log_tlast  = 1'b0;
      bus.rec_ready         = 1'b1;
      #12;
      chk("rst_tready", bus.s_axis_log_tready, 0);
      chk("rst_valid", bus.rec_valid, 0);
      chk("rst_id", bus.rec_log_id, 0);
      chk("rst_hdr", bus.err_header_count, 0);
      chk("rst_len", bus.err_length_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      send(mk(16'h0007, 32'h02425AFF, 16'd40), 6, 0);

      // hold off the consumer
      @(posedge clk);
      #1 bus.rec_ready = 1'b0;
      r = mk(16'h0011, 32'h02425AFF, 16'd40);
      send(r, 6, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_tready", bus.s_axis_log_tready, 0);
         chk("bp_id", bus.rec_log_id, r[47:32]);
         chk("bp_plost", bus.rec_pongs_lost, r[383:320]);
      end
      @(posedge clk);
      #1 bus.rec_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release", bus.s_axis_log_tready, 1);
      send(mk(16'h0012, 32'h02425AFF, 16'd40), 6, 0);

      send(mk(16'h0020, 32'h02425AFE, 16'd40), 6, 1);
      send(mk(16'h0021, 32'h02425AFF, 16'd40), 6, 0);
      send(mk(16'h0022, 32'h02425AFF, 16'd41), 6, 1);
      send(mk(16'h0023, 32'h02425AFF, 16'd40), 6, 0);

      send(mk(16'h0030, 32'h02425AFF, 16'd40), 4, 2);
      send(mk(16'h0031, 32'h02425AFF, 16'd40), 6, 0);
      send(mk(16'h0032, 32'h02425AFF, 16'd40), 8, 2);
      send(mk(16'h0033, 32'h02425AFF, 16'd40), 6, 0);

      // reset in the middle of a record
      r = mk(16'h0040, 32'h02425AFF, 16'd40);
      for (int i = 0; i < 3; i++) drive_beat(r[i*64 +: 64], 1'b0);
      @(negedge clk);
      bus.s_axis_log_tvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_hdr = 0;
      exp_len = 0;
      chk("mr_tready", bus.s_axis_log_tready, 0);
      chk("mr_valid", bus.rec_valid, 0);
      chk("mr_id", bus.rec_log_id, 0);
      chk("mr_hdr", bus.err_header_count, 0);
      chk("mr_len", bus.err_length_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(mk(16'h0041, 32'h02425AFF, 16'd40), 6, 0);

      // counter saturation
      @(negedge clk);
      force dut.hdr_q = 32'hFFFF_FFFE;
      #1 release dut.hdr_q;
      exp_hdr = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++)
         send(mk(16'h0050, 32'h12345678, 16'd40), 6, 1);
      chk("sat_hdr", bus.err_header_count, 32'hFFFF_FFFF);

      repeat (5) @(negedge clk);
      chk("sb_left", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
